// File: rtl/bounds_table_dlk.sv
// Bounds table for data-leak detection: a DEPTH-entry set of valid-tagged block bases
// with alloc/free/clear maintenance and NUM_CHK pipelined "next higher base" checks.
module bounds_table_dlk #(
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 32,
    parameter int NUM_CHK = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      clear_i,
    input  logic                      alloc_i,
    input  logic [ADDR_W-1:0]         alloc_base_i,
    input  logic                      free_i,
    input  logic [ADDR_W-1:0]         free_base_i,
    output logic                      evict_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic                      full_o,
    input  logic [NUM_CHK-1:0]        chk_req_i,
    input  logic [NUM_CHK*ADDR_W-1:0] chk_base_i,
    input  logic [NUM_CHK*ADDR_W-1:0] chk_addr_i,
    output logic [NUM_CHK-1:0]        chk_rsp_o,
    output logic [NUM_CHK-1:0]        chk_ovf_o,
    output logic [NUM_CHK*ADDR_W-1:0] chk_next_o
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    logic [ADDR_W-1:0] entry_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [IW-1:0]     cursor_q;

    logic              free_en;
    logic [DEPTH-1:0]  valid_free;
    logic              dup;
    logic              has_hole;
    logic [IW-1:0]     hole_idx;
    logic              wr_en;
    logic              evict_d;
    logic [IW-1:0]     wr_idx;
    logic [DEPTH-1:0]  valid_d;
    logic [CW-1:0]     count_d;

    // A free and alloc of the same base in one cycle cancel out, leaving the entry in place.
    assign free_en = free_i && !(alloc_i && (free_base_i == alloc_base_i));

    // NOTE: every signal written in an always_comb gets a default at the top of the block,
    // so no path through the ifs can leave it unassigned and infer a latch.
    always_comb begin
        valid_free = valid_q;
        dup        = 1'b0;
        has_hole   = 1'b0;
        hole_idx   = '0;
        count_d    = '0;

        for (int i = 0; i < DEPTH; i++) begin
            if (free_en && valid_q[i] && (entry_q[i] == free_base_i)) begin
                valid_free[i] = 1'b0;
            end
        end

        for (int i = 0; i < DEPTH; i++) begin
            if (valid_free[i] && (entry_q[i] == alloc_base_i)) begin
                dup = 1'b1;
            end
        end

        // Scan downwards so the last hit is the lowest-index free slot.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_free[i]) begin
                has_hole = 1'b1;
                hole_idx = IW'(i);
            end
        end

        wr_en   = alloc_i && !dup;
        evict_d = wr_en && !has_hole;
        wr_idx  = has_hole ? hole_idx : cursor_q;

        valid_d = valid_free;
        if (wr_en) begin
            valid_d[wr_idx] = 1'b1;
        end

        for (int i = 0; i < DEPTH; i++) begin
            count_d = count_d + CW'(valid_d[i]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // NOTE: the entry array is reset together with the valid bits, so the
            // table content is fully defined after reset and after a clear.
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            valid_q  <= '0;
            cursor_q <= '0;
            evict_o  <= 1'b0;
            count_o  <= '0;
            full_o   <= 1'b0;
        end else if (clear_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            valid_q  <= '0;
            cursor_q <= '0;
            evict_o  <= 1'b0;
            count_o  <= '0;
            full_o   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            if (wr_en) begin
                entry_q[wr_idx] <= alloc_base_i;
            end
            if (evict_d) begin
                cursor_q <= cursor_q + 1'b1;
            end
            evict_o <= evict_d;
            count_o <= count_d;
            full_o  <= (count_d == CW'(DEPTH));
        end
    end

    logic [ADDR_W-1:0]  nxt_d [NUM_CHK];
    logic [NUM_CHK-1:0] ovf_d;

    // Each channel looks at the registered table, so same-cycle updates are invisible.
    always_comb begin
        logic found;
        ovf_d = '0;
        for (int c = 0; c < NUM_CHK; c++) begin
            found    = 1'b0;
            nxt_d[c] = '1;
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && (entry_q[i] > chk_base_i[c*ADDR_W +: ADDR_W]) &&
                    (!found || (entry_q[i] < nxt_d[c]))) begin
                    nxt_d[c] = entry_q[i];
                    found    = 1'b1;
                end
            end
            ovf_d[c] = found && (chk_addr_i[c*ADDR_W +: ADDR_W] >= nxt_d[c]);
        end
    end

    // Clear leaves this pipeline alone so an in-flight response still reports pre-clear state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            chk_rsp_o  <= '0;
            chk_ovf_o  <= '0;
            chk_next_o <= '1;
        end else begin
            chk_rsp_o <= chk_req_i;
            for (int c = 0; c < NUM_CHK; c++) begin
                if (chk_req_i[c]) begin
                    chk_ovf_o[c]                    <= ovf_d[c];
                    chk_next_o[c*ADDR_W +: ADDR_W] <= nxt_d[c];
                end
            end
        end
    end

endmodule

// File: doc/bounds_table_dlk.md
Name: bounds_table_dlk

Overview:
Parametrised successor of the single-port circular base-address buffer in the INSA data-leak-detection path.
- Holds up to DEPTH allocated block base addresses, each tagged with an explicit valid bit, so address 0 is a legal base.
- Supports allocate, free and clear operations.
- Serves NUM_CHK independent bounds-check channels, each with a registered response, so load/store ports can each be checked against the next higher allocated block.

Parameters:
ADDR_W, 32, width of base and access addresses.
DEPTH, 32, number of table entries (power of two, >= 2).
NUM_CHK, 2, number of independent check channels.

Ports:
clk_i  in  1  clock.
rst_i  in  1  asynchronous reset, active-high.
clear_i  in  1  synchronous table flush (debug/soft reset).
alloc_i  in  1  insert alloc_base_i.
alloc_base_i  in  ADDR_W  base address to insert.
free_i  in  1  invalidate the entry equal to free_base_i.
free_base_i  in  ADDR_W  base address to remove.
evict_o  out  1  one-cycle pulse: an alloc overwrote a valid entry.
count_o  out  $clog2(DEPTH)+1  number of valid entries.
full_o  out  1  count_o == DEPTH.
chk_req_i  in  NUM_CHK  per-channel check request.
chk_base_i  in  NUM_CHK*ADDR_W  per-channel pointer base (channel c at bits [c*ADDR_W +: ADDR_W]).
chk_addr_i  in  NUM_CHK*ADDR_W  per-channel access address.
chk_rsp_o  out  NUM_CHK  response valid, 1 cycle after chk_req_i.
chk_ovf_o  out  NUM_CHK  overflow flag, qualified by chk_rsp_o.
chk_next_o  out  NUM_CHK*ADDR_W  next higher base found; all-ones if none.

Behaviour:
- Reset (rst_i high, asynchronous):
  - all valid bits 0, entries 0, cursor 0.
  - evict_o, chk_rsp_o, chk_ovf_o = 0; chk_next_o = all-ones; count_o = 0.
- Operation priority per clock:
  - clear_i set: same effect as reset, except applied synchronously; alloc and free in that cycle are ignored.
  - otherwise free is applied first, then alloc, both in the same cycle.
- Free:
  - invalidates every valid entry whose base equals free_base_i.
  - no match: no-op.
  - free does not move the cursor.
- Alloc:
  - Duplicate: if a valid entry already equals alloc_base_i (after the same-cycle free), no change, no evict. Consequence: alloc and free of the same address in one cycle leaves the address present, in its original slot.
  - Otherwise, if any entry is invalid: write into the lowest-index invalid entry (free applied first, so a slot freed this cycle is usable).
  - Otherwise (table full): overwrite entry[cursor], pulse evict_o next cycle, cursor = (cursor+1) mod DEPTH.
- count_o and full_o are registered and reflect the table after the update.
- Check channel c (independent, all channels may fire in the same cycle):
  - evaluated combinationally against table state at the request edge (pre-update; same-cycle alloc/free are not visible).
  - next = minimum valid entry strictly greater than chk_base_i[c]; all-ones if none.
  - ovf = chk_addr_i[c] >= next, but only when a next exists; if none, ovf = 0.
  - Comparisons are unsigned, ADDR_W wide.
  - Results are registered: chk_rsp_o[c], chk_ovf_o[c], chk_next_o[c] valid exactly 1 cycle after chk_req_i[c]; chk_rsp_o low otherwise.
  - ovf/next outputs hold their last value when no request is present.
- Back-to-back requests every cycle are supported, fully pipelined with no stall.
- A clear or reset asserted while a response is in flight:
  - reset kills the response.
  - clear does not; the response reflects pre-clear state.

Test Plan:
- Reset then alloc 0x1000, 0x2000, 0x0 -> count_o=3; check base=0x0 addr=0x0FFF -> rsp 1 cycle later, next=0x1000, ovf=0; addr=0x1000 -> ovf=1.
- Alloc 0x1000 twice, then alloc 0x3000 -> count_o=2, no evict; free 0x1000, then check base=0x800 addr=0x2000 -> next=0x3000, ovf=0.
- Fill DEPTH=32 entries with 0x100*k (k=1..32), then alloc 0x9000 -> evict_o pulses, entry 0 (0x100) replaced, cursor=1, count_o stays 32, full_o=1.
- Same-cycle free 0x200 + alloc 0x200 -> entry unchanged, count unchanged; same-cycle free 0x200 + alloc 0x5000 on full table -> 0x5000 placed in freed slot, no evict.
- Both channels request in the same cycle as alloc 0x1800: ch0 base=0x1000 addr=0x1900 -> next=0x2000, ovf=0 (alloc not yet visible); repeated next cycle -> next=0x1800, ovf=1; ch1 base=0xFFFF_0000 -> next=all-ones, ovf=0.
- Assert clear_i with alloc_i in the same cycle -> count_o=0, alloc ignored; assert rst_i mid-cycle with chk_req_i high -> chk_rsp_o drops immediately, outputs at reset values.
